// File: rtl/regfile_port_arbiter.sv
// Two-client arbiter/sequencer for the 64 x 32 register file: one write or dual read per cycle.
// Define RF_ARB_FIXED_PRIO_EN for client-0 fixed priority with starvation relief; default is round-robin.
module regfile_port_arbiter #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_rd,
  input  logic [ADDR_W-1:0] c0_rs,
  input  logic [ADDR_W-1:0] c0_rt,
  input  logic [DATA_W-1:0] c0_wdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_rd,
  input  logic [ADDR_W-1:0] c1_rs,
  input  logic [ADDR_W-1:0] c1_rt,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c0_gnt,
  output logic              c1_gnt,
  output logic              c0_rvalid,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] c0_rs_data,
  output logic [DATA_W-1:0] c0_rt_data,
  output logic [DATA_W-1:0] c1_rs_data,
  output logic [DATA_W-1:0] c1_rt_data,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [ADDR_W-1:0] rf_rs,
  output logic [ADDR_W-1:0] rf_rt,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_rs_out,
  input  logic [DATA_W-1:0] rf_rt_out
);

  typedef enum logic {CLIENT0, CLIENT1} client_e;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be within 1..15");
  end

  logic              issue_valid;
  logic              issue_read;
  client_e           issue_client;
  logic              grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_rd;
  logic [ADDR_W-1:0] sel_rs;
  logic [ADDR_W-1:0] sel_rt;
  logic [DATA_W-1:0] sel_wdata;
  logic              cap_c0;
  logic              cap_c1;

`ifdef RF_ARB_FIXED_PRIO_EN
  logic [3:0] starve_cnt;
  logic       starved;

  assign starved = (starve_cnt >= 4'(STARVE_LIMIT));

  always_comb begin
    c1_gnt = ~reset & c1_req & (~c0_req | starved);
    c0_gnt = ~reset & c0_req & ~c1_gnt;
  end

  // Counts only cycles where client 1 is actively waiting; saturates rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (c1_gnt || !c1_req) begin
      starve_cnt <= '0;
    end else if (starve_cnt != '1) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  client_e last_served;

  always_comb begin
    c0_gnt = ~reset & c0_req & (~c1_req | (last_served == CLIENT1));
    c1_gnt = ~reset & c1_req & (~c0_req | (last_served == CLIENT0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_served <= CLIENT1;
    end else if (c0_gnt) begin
      last_served <= CLIENT0;
    end else if (c1_gnt) begin
      last_served <= CLIENT1;
    end
  end
`endif

  always_comb begin
    grant     = c0_gnt | c1_gnt;
    sel_we    = c1_gnt ? c1_we    : c0_we;
    sel_rd    = c1_gnt ? c1_rd    : c0_rd;
    sel_rs    = c1_gnt ? c1_rs    : c0_rs;
    sel_rt    = c1_gnt ? c1_rt    : c0_rt;
    sel_wdata = c1_gnt ? c1_wdata : c0_wdata;
    cap_c0    = issue_valid & issue_read & (issue_client == CLIENT0);
    cap_c1    = issue_valid & issue_read & (issue_client == CLIENT1);
  end

  // Issue stage: command registers drive the register file for the cycle after the grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid  <= 1'b0;
      issue_read   <= 1'b0;
      issue_client <= CLIENT0;
      rf_write     <= 1'b0;
      rf_rd        <= '0;
      rf_rs        <= '0;
      rf_rt        <= '0;
      rf_data_in   <= '0;
    end else begin
      issue_valid <= grant;
      if (grant) begin
        issue_read   <= ~sel_we;
        issue_client <= c1_gnt ? CLIENT1 : CLIENT0;
        rf_write     <= sel_we;
        rf_rd        <= sel_rd;
        rf_rs        <= sel_rs;
        rf_rt        <= sel_rt;
        rf_data_in   <= sel_wdata;
      end else begin
        rf_write <= 1'b0;
      end
    end
  end

  // Capture stage: the register file has resolved the read on the falling edge in between.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c0_rvalid  <= 1'b0;
      c1_rvalid  <= 1'b0;
      c0_rs_data <= '0;
      c0_rt_data <= '0;
      c1_rs_data <= '0;
      c1_rt_data <= '0;
    end else begin
      c0_rvalid <= cap_c0;
      c1_rvalid <= cap_c1;
      if (cap_c0) begin
        c0_rs_data <= rf_rs_out;
        c0_rt_data <= rf_rt_out;
      end
      if (cap_c1) begin
        c1_rs_data <= rf_rs_out;
        c1_rt_data <= rf_rt_out;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: falling-edge register file model plus a transaction-level reference.
module tb_regfile_port_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          c0_req, c0_we, c1_req, c1_we;
  logic [AW-1:0] c0_rd, c0_rs, c0_rt, c1_rd, c1_rs, c1_rt;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic          c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
  logic [DW-1:0] c0_rs_data, c0_rt_data, c1_rs_data, c1_rt_data;
  logic          rf_write;
  logic [AW-1:0] rf_rd, rf_rs, rf_rt;
  logic [DW-1:0] rf_data_in;
  logic [DW-1:0] rf_rs_out = '0;
  logic [DW-1:0] rf_rt_out = '0;
  logic [DW-1:0] rf_mem [64] = '{default: '0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_we(c0_we), .c0_rd(c0_rd), .c0_rs(c0_rs), .c0_rt(c0_rt), .c0_wdata(c0_wdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_rd(c1_rd), .c1_rs(c1_rs), .c1_rt(c1_rt), .c1_wdata(c1_wdata),
    .c0_gnt(c0_gnt), .c1_gnt(c1_gnt), .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
    .c0_rs_data(c0_rs_data), .c0_rt_data(c0_rt_data), .c1_rs_data(c1_rs_data), .c1_rt_data(c1_rt_data),
    .rf_write(rf_write), .rf_rd(rf_rd), .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_data_in(rf_data_in),
    .rf_rs_out(rf_rs_out), .rf_rt_out(rf_rt_out)
  );

  // Register file: write first, then read, on the falling edge.
  always @(negedge clk) begin
    if (rf_write) rf_mem[rf_rd] = rf_data_in;
    rf_rs_out = rf_mem[rf_rs];
    rf_rt_out = rf_mem[rf_rt];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          v;
    bit          rd;
    int          cl;
    logic [31:0] rs;
    logic [31:0] rt;
  } acc_t;

  // Reference model: architectural contents, arbitration history, pending read.
  logic [DW-1:0] shadow [64];
  int            last_srv;
  int            wait_cnt;
  acc_t          pend;
  logic [DW-1:0] e_c0_rs, e_c0_rt, e_c1_rs, e_c1_rt, e_din;
  logic          e_write;
  logic [AW-1:0] e_rd, e_rs, e_rt;
  int            last_g;
  int            obs_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_srv = 1;
    wait_cnt = 0;
    pend.v   = 0;
    e_c0_rs = '0; e_c0_rt = '0; e_c1_rs = '0; e_c1_rt = '0;
    e_write = 1'b0; e_rd = '0; e_rs = '0; e_rt = '0; e_din = '0;
  endtask

  function automatic int model_grant();
    if (c0_req && c1_req) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      return (wait_cnt >= SL) ? 1 : 0;
`else
      return (last_srv == 0) ? 1 : 0;
`endif
    end
    if (c0_req) return 0;
    if (c1_req) return 1;
    return -1;
  endfunction

  task automatic drive(input int c, input bit req, input bit we, input int rd, input int rs,
                       input int rt, input logic [31:0] wd);
    if (c == 0) begin
      c0_req = req; c0_we = we; c0_rd = AW'(rd); c0_rs = AW'(rs); c0_rt = AW'(rt); c0_wdata = wd;
    end else begin
      c1_req = req; c1_we = we; c1_rd = AW'(rd); c1_rs = AW'(rs); c1_rt = AW'(rt); c1_wdata = wd;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_c0_gnt"}, 32'(c0_gnt), 0);
    chk({tag, "_c1_gnt"}, 32'(c1_gnt), 0);
    chk({tag, "_c0_rvalid"}, 32'(c0_rvalid), 0);
    chk({tag, "_c1_rvalid"}, 32'(c1_rvalid), 0);
    chk({tag, "_c0_rs_data"}, c0_rs_data, 0);
    chk({tag, "_c0_rt_data"}, c0_rt_data, 0);
    chk({tag, "_c1_rs_data"}, c1_rs_data, 0);
    chk({tag, "_c1_rt_data"}, c1_rt_data, 0);
    chk({tag, "_rf_write"}, 32'(rf_write), 0);
    chk({tag, "_rf_rd"}, 32'(rf_rd), 0);
    chk({tag, "_rf_rs"}, 32'(rf_rs), 0);
    chk({tag, "_rf_rt"}, 32'(rf_rt), 0);
    chk({tag, "_rf_data_in"}, rf_data_in, 0);
  endtask

  // One clock: check grant before the edge, advance the model at the edge, check registered outputs after.
  task automatic tick();
    int            g;
    acc_t          done;
    bit            we;
    logic [AW-1:0] rd, rs, rt;
    logic [DW-1:0] wd;
    #1;
    g = model_grant();
    chk("c0_gnt", 32'(c0_gnt), 32'(g == 0));
    chk("c1_gnt", 32'(c1_gnt), 32'(g == 1));
    obs_q.push_back(c0_gnt ? 0 : (c1_gnt ? 1 : -1));
    @(posedge clk);
    done   = pend;
    pend.v = 0;
    if (g >= 0) begin
      if (g == 0) begin we = c0_we; rd = c0_rd; rs = c0_rs; rt = c0_rt; wd = c0_wdata; end
      else        begin we = c1_we; rd = c1_rd; rs = c1_rs; rt = c1_rt; wd = c1_wdata; end
      pend.v  = 1; pend.rd = !we; pend.cl = g;
      pend.rs = shadow[rs]; pend.rt = shadow[rt];
      if (we) shadow[rd] = wd;
      e_write = we; e_rd = rd; e_rs = rs; e_rt = rt; e_din = wd;
      last_srv = g;
    end else begin
      e_write = 1'b0;
    end
    if (g == 1 || !c1_req) wait_cnt = 0;
    else if (wait_cnt < 15) wait_cnt++;
    if (done.v && done.rd) begin
      if (done.cl == 0) begin e_c0_rs = done.rs; e_c0_rt = done.rt; end
      else              begin e_c1_rs = done.rs; e_c1_rt = done.rt; end
    end
    last_g = g;
    #1;
    chk("c0_rvalid", 32'(c0_rvalid), 32'(done.v && done.rd && done.cl == 0));
    chk("c1_rvalid", 32'(c1_rvalid), 32'(done.v && done.rd && done.cl == 1));
    chk("c0_rs_data", c0_rs_data, e_c0_rs);
    chk("c0_rt_data", c0_rt_data, e_c0_rt);
    chk("c1_rs_data", c1_rs_data, e_c1_rs);
    chk("c1_rt_data", c1_rt_data, e_c1_rt);
    chk("rf_write", 32'(rf_write), 32'(e_write));
    chk("rf_rd", 32'(rf_rd), 32'(e_rd));
    chk("rf_rs", 32'(rf_rs), 32'(e_rs));
    chk("rf_rt", 32'(rf_rt), 32'(e_rt));
    chk("rf_data_in", rf_data_in, e_din);
  endtask

  initial begin
    int          pat[6];
    logic [31:0] prior;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 64; i++) shadow[i] = '0;
    model_reset();

    // Reset state, with both clients requesting.
    #2;
    drive(0, 1, 0, 1, 2, 3, '0);
    drive(1, 1, 1, 4, 5, 6, 32'h1);
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    check_all_zero("reset_edge");
    drive(0, 0, 0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, 0, 0, '0);
    @(negedge clk); #1;
    reset = 1'b0;

    // Write then read across clients.
    drive(0, 1, 1, 5, 0, 0, 32'hDEADBEEF);
    tick();
    drive(0, 0, 0, 0, 0, 0, '0);
    drive(1, 1, 0, 0, 5, 0, '0);
    tick();
    drive(1, 0, 0, 0, 0, 0, '0);
    tick();
    chk("wr_rd_c1_rs", c1_rs_data, 32'hDEADBEEF);
    chk("wr_rd_c1_rt", c1_rt_data, 32'h0);

    // Write whose rs matches rd: no read result, later read sees the data.
    drive(0, 1, 1, 9, 9, 0, 32'h12345678);
    tick();
    drive(0, 1, 0, 0, 9, 5, '0);
    tick();
    drive(0, 0, 0, 0, 0, 0, '0);
    tick();
    chk("wr_same_rs_c0_rs", c0_rs_data, 32'h12345678);
    chk("wr_same_rs_c0_rt", c0_rt_data, 32'hDEADBEEF);

    // Contention: serve client 1 alone first so client 0 wins the first tie.
    drive(1, 1, 0, 0, 1, 2, '0);
    tick();
    obs_q.delete();
    drive(0, 1, 0, 0, 5, 9, '0);
    drive(1, 1, 0, 0, 9, 5, '0);
    for (int i = 0; i < 6; i++) tick();
    drive(0, 0, 0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, 0, 0, '0);
    tick();
`ifdef RF_ARB_FIXED_PRIO_EN
    pat = '{0, 0, 0, 0, 1, 0};
`else
    pat = '{0, 1, 0, 1, 0, 1};
`endif
    for (int i = 0; i < 6; i++) chk($sformatf("contend_grant%0d", i), 32'(obs_q[i]), 32'(pat[i]));

    // Reset arriving between the grant edge and the falling edge of a write.
    drive(1, 1, 1, 3, 0, 0, 32'hA5A50003);
    tick();
    drive(1, 0, 0, 0, 0, 0, '0);
    tick();
    prior = shadow[3];
    drive(0, 1, 1, 3, 0, 0, 32'hFFFFFFFF);
    tick();
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    shadow[3] = prior;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, '0);
    @(negedge clk);
    @(posedge clk); #1;
    check_all_zero("mid_reset_hold");
    #1;
    reset = 1'b0;
    drive(0, 1, 0, 0, 3, 3, '0);
    tick();
    drive(0, 0, 0, 0, 0, 0, '0);
    tick();
    chk("reset_drop_r3", c0_rs_data, 32'hA5A50003);

    // Withdrawal: client 1 pulses for one cycle while client 0 takes the grant.
    drive(1, 1, 0, 0, 7, 7, '0);
    tick();
    drive(1, 0, 0, 0, 0, 0, '0);
    tick();
    obs_q.delete();
    drive(0, 1, 0, 0, 1, 2, '0);
    drive(1, 1, 0, 0, 3, 4, '0);
    tick();
    drive(0, 0, 0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, 0, 0, '0);
    tick();
    tick();
    chk("withdraw_grant", 32'(obs_q[0]), 32'(0));
    chk("withdraw_c1_rvalid", 32'(c1_rvalid), 0);

    // Randomized traffic; requests hold until granted, occasionally withdrawn.
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 2; c++) begin
        bit busy;
        busy = (c == 0) ? c0_req : c1_req;
        if (busy && last_g == c) busy = 0;
        if (busy && $urandom_range(0, 9) == 0) begin
          drive(c, 0, 0, 0, 0, 0, '0);
        end else if (!busy) begin
          if ($urandom_range(0, 9) < 6)
            drive(c, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom);
          else
            drive(c, 0, 0, 0, 0, 0, '0);
        end
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, 0, 0, '0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
